// File: rtl/rt_sched_pkg.sv
// Shared definitions for the pixel job scheduler: FSM state encoding and
// default widths for image dimensions and camera vector components.
package rt_sched_pkg;

    localparam int DEF_DIM_W   = 13;
    localparam int DEF_COORD_W = 11;
    // Four vectors (position, direction, right, up) of three components each.
    localparam int CAM_CFG_W   = 12 * DEF_COORD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster-order x/y pixel coordinate counter with start-of-frame and
// end-of-line decode. Cleared at frame start, advanced once per issued job.
module pixel_coord_counter
    import rt_sched_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             last_o
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic [DIM_W-1:0] x_max;
    logic [DIM_W-1:0] y_max;

    assign x_max  = width_i - DIM_W'(1);
    assign y_max  = height_i - DIM_W'(1);
    assign sof_o  = (x_q == '0) && (y_q == '0);
    assign eol_o  = (x_q == x_max);
    assign last_o = eol_o && (y_q == y_max);
    assign x_o    = x_q;
    assign y_o    = y_q;

    // Next coordinate: clear wins, otherwise step x and wrap into the next row.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_job_scheduler.sv
// Pixel job scheduler: walks the image in raster order, issuing one job per
// pixel to the tracing core while bounding the number of jobs in flight, and
// reports frame completion once every issued pixel has come back.
// Optional feature macro: CAMERA_SHADOW_EN -- latch camera and image size at
// frame start so the tracing core sees a stable configuration for the frame.
module pixel_job_scheduler
    import rt_sched_pkg::*;
#(
    parameter int DIM_W           = DEF_DIM_W,
    parameter int COORD_W         = DEF_COORD_W,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_en,
    input  logic [DIM_W-1:0]     cfg_width,
    input  logic [DIM_W-1:0]     cfg_height,
    input  logic [12*COORD_W-1:0] cfg_cam,
    output logic [12*COORD_W-1:0] cam_out,
    output logic                 job_valid,
    input  logic                 job_ready,
    output logic [DIM_W-1:0]     job_x,
    output logic [DIM_W-1:0]     job_y,
    output logic                 job_sof,
    output logic                 job_eol,
    input  logic                 result_fire,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    sched_state_e     state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [DIM_W-1:0] eff_width;
    logic [DIM_W-1:0] eff_height;
    logic             fire;
    logic             res_dec;
    logic             coord_clear;
    logic             coord_sof;
    logic             coord_eol;
    logic             coord_last;

`ifdef CAMERA_SHADOW_EN
    logic [12*COORD_W-1:0] cam_q;
    logic [DIM_W-1:0]      width_q;
    logic [DIM_W-1:0]      height_q;

    // Capture the frame configuration once, while loading a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cam_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (state_q == ST_LOAD) begin
            cam_q    <= cfg_cam;
            width_q  <= cfg_width;
            height_q <= cfg_height;
        end
    end

    assign cam_out    = cam_q;
    assign eff_width  = width_q;
    assign eff_height = height_q;
`else
    assign cam_out    = cfg_cam;
    assign eff_width  = cfg_width;
    assign eff_height = cfg_height;
`endif

    // Valid comes only from registered state, never from job_ready.
    assign job_valid   = (state_q == ST_ISSUE) && (out_q < OUT_MAX);
    assign fire        = job_valid && job_ready;
    assign res_dec     = result_fire && (out_q != '0);
    assign coord_clear = (state_q == ST_LOAD);
    assign job_sof     = job_valid && coord_sof;
    assign job_eol     = job_valid && coord_eol;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;

    pixel_coord_counter #(
        .DIM_W(DIM_W)
    ) u_coord (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (coord_clear),
        .advance_i(fire),
        .width_i  (eff_width),
        .height_i (eff_height),
        .x_o      (job_x),
        .y_o      (job_y),
        .sof_o    (coord_sof),
        .eol_o    (coord_eol),
        .last_o   (coord_last)
    );

    // In-flight job count: issue adds, a returned result removes, both cancel.
    always_comb begin
        out_d = out_q;
        if (fire && !res_dec) begin
            out_d = out_q + OUT_W'(1);
        end else if (!fire && res_dec) begin
            out_d = out_q - OUT_W'(1);
        end
    end

    // Frame sequencing: next state, frame completion pulse and frame counter.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An empty image produces no jobs and no completion.
                if ((cfg_width == '0) || (cfg_height == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fire && coord_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    frame_done  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = run_en ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, in-flight counter and frame counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_pixel_job_scheduler.sv
// Self-checking bench for pixel_job_scheduler. A raster-order scoreboard
// (job index -> expected x,y) and an in-flight tally check every cycle;
// directed sequences pin latency, throttling, reset and frame counts.
module tb_pixel_job_scheduler;

    localparam int DIM_W   = 13;
    localparam int COORD_W = 11;
    localparam int MAXO    = 16;
    localparam int CAM_W   = 12 * COORD_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run_en = 1'b0;
    logic [DIM_W-1:0] cfg_width = 13'd4;
    logic [DIM_W-1:0] cfg_height = 13'd2;
    logic [CAM_W-1:0] cfg_cam = '0;
    logic [CAM_W-1:0] cam_out;
    logic             job_valid;
    logic             job_ready = 1'b0;
    logic [DIM_W-1:0] job_x;
    logic [DIM_W-1:0] job_y;
    logic             job_sof;
    logic             job_eol;
    logic             result_fire = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_cnt;

    pixel_job_scheduler #(
        .DIM_W          (DIM_W),
        .COORD_W        (COORD_W),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_cam    (cfg_cam),
        .cam_out    (cam_out),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_x      (job_x),
        .job_y      (job_y),
        .job_sof    (job_sof),
        .job_eol    (job_eol),
        .result_fire(result_fire),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- stimulus driver for job_ready / result_fire ----------
    int         ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
    int         res_mode   = 0;   // 0: none, 1: each job returns 3 cycles later, 2: manual pulses
    int         res_req    = 0;
    int         res_done   = 0;
    logic       fire_n     = 1'b0;
    logic [2:0] dly        = '0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       job_ready = 1'b0;
            1:       job_ready = 1'b1;
            default: job_ready = ($urandom_range(3, 0) != 0);
        endcase
        if (reset) begin
            dly         = '0;
            result_fire = 1'b0;
            res_done    = res_req;
        end else begin
            dly = {dly[1:0], fire_n};
            if (res_mode == 1) begin
                result_fire = dly[2];
            end else if (res_mode == 2 && res_done != res_req) begin
                result_fire = 1'b1;
                res_done++;
            end else begin
                result_fire = 1'b0;
            end
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    int               k          = 0;   // jobs issued in the current frame
    int               model_out  = 0;   // jobs in flight
    int               frames_exp = 0;
    int               last_frame_jobs = 0;
    int               last_x = 0, last_y = 0, last_eol = 0;
    logic             hold = 1'b0;
    logic [DIM_W-1:0] hx, hy;
    logic             hsof, heol;

    always @(negedge clk) begin
        int w, h;
        logic f;
        w = int'(cfg_width);
        h = int'(cfg_height);
        if (reset) begin
            k = 0; model_out = 0; frames_exp = 0; hold = 1'b0; fire_n = 1'b0;
        end else begin
            check("frame_cnt", 32'(frame_cnt), 32'(frames_exp));
`ifndef CAMERA_SHADOW_EN
            tests_run++;
            if (cam_out !== cfg_cam) begin
                fails++;
                $display("[TB] FAIL cam_passthru: got %h, expected %h", cam_out, cfg_cam);
            end
`endif
            if (hold) begin
                check("hold_valid", 32'(job_valid), 32'd1);
                check("hold_x", 32'(job_x), 32'(hx));
                check("hold_y", 32'(job_y), 32'(hy));
                check("hold_sof", 32'(job_sof), 32'(hsof));
                check("hold_eol", 32'(job_eol), 32'(heol));
            end
            if (job_valid) begin
                check("valid_under_cap", 32'(model_out < MAXO), 32'd1);
                check("valid_in_frame", 32'(k < w * h), 32'd1);
            end
            if (frame_done) begin
                check("frame_jobs", 32'(k), 32'(w * h));
                check("drain_empty", 32'(model_out), 32'd0);
            end
            f = job_valid && job_ready;
            if (f && w > 0) begin
                check("job_x", 32'(job_x), 32'(k % w));
                check("job_y", 32'(job_y), 32'(k / w));
                check("job_sof", 32'(job_sof), 32'(k == 0));
                check("job_eol", 32'(job_eol), 32'((k % w) == w - 1));
                last_x = int'(job_x); last_y = int'(job_y); last_eol = int'(job_eol);
                k++;
            end
            if (f) model_out++;
            if (result_fire && (model_out > 0 || f)) begin
                if (!(f && model_out == 1 && !result_fire)) model_out--;
            end
            if (frame_done) begin
                last_frame_jobs = k;
                k = 0;
                frames_exp++;
            end
            hold = job_valid && !job_ready;
            hx = job_x; hy = job_y; hsof = job_sof; heol = job_eol;
            fire_n = f;
        end
    end

    // ---------------- directed sequences ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (frame_done !== 1'b1) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (job_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (job_valid !== 1'b1) check({name, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_k(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (k < target && n < budget) begin
            step();
            n++;
        end
        if (k < target) check({name, "_jobs_timeout"}, 32'(k), 32'(target));
    endtask

    initial begin
        logic [CAM_W-1:0] cam_a;
        logic [CAM_W-1:0] cam_b;
        int vcount, bcount;
        cam_a = {12{11'h155}};
        cam_b = {12{11'h2AA}};
        cfg_cam = cam_a;

        // Reset state
        repeat (2) step();
        check("rst_valid", 32'(job_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_x", 32'(job_x), 32'd0);
        check("rst_y", 32'(job_y), 32'd0);
        check("rst_sof", 32'(job_sof), 32'd0);
        reset = 1'b0;
        step();

        // Test 4: zero width loops LOAD<->IDLE without jobs or completions
        cfg_width  = 13'd0;
        cfg_height = 13'd2;
        run_en     = 1'b1;
        vcount = 0; bcount = 0;
        repeat (20) begin
            step();
            if (job_valid) vcount++;
            if (busy) bcount++;
        end
        check("t4_valid_cycles", 32'(vcount), 32'd0);
        check("t4_busy_cycles", 32'(bcount), 32'd10);
        run_en = 1'b0;
        repeat (2) step();
        check("t4_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // Test 1: 4x2 frame, results returned 3 cycles after each job
        cfg_width  = 13'd4;
        cfg_height = 13'd2;
        res_mode   = 1;
        ready_mode = 1;
        run_en     = 1'b1;
        step();
        check("t1_load_valid", 32'(job_valid), 32'd0);
        check("t1_load_busy", 32'(busy), 32'd1);
        step();
        check("t1_latency_valid", 32'(job_valid), 32'd1);
        check("t1_first_sof", 32'(job_sof), 32'd1);
        run_en = 1'b0;
        wait_done(100, "t1");
        check("t1_jobs", 32'(last_frame_jobs), 32'd8);
        check("t1_last_x", 32'(last_x), 32'd3);
        check("t1_last_y", 32'(last_y), 32'd1);
        check("t1_last_eol", 32'(last_eol), 32'd1);
        step();
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Test 5: run_en dropped at job 5 of 8, frame still completes
        run_en = 1'b1;
        wait_k(5, 50, "t5");
        run_en = 1'b0;
        wait_done(100, "t5");
        check("t5_jobs", 32'(last_frame_jobs), 32'd8);
        step();
        check("t5_frame_cnt", 32'(frame_cnt), 32'd2);
        check("t5_idle", 32'(busy), 32'd0);

        // Test 2: in-flight cap with no results returning
        cfg_width  = 13'd200;
        cfg_height = 13'd200;
        res_mode   = 2;
        run_en     = 1'b1;
        repeat (40) step();
        check("t2_cap_jobs", 32'(k), 32'd16);
        check("t2_cap_valid", 32'(job_valid), 32'd0);
        res_req = res_req + 1;
        repeat (10) step();
        check("t2_one_more", 32'(k), 32'd17);
        check("t2_one_more_valid", 32'(job_valid), 32'd0);
        // Second result lands on the same edge as the refill fire
        res_req = res_req + 2;
        repeat (10) step();
        check("t2_simul_jobs", 32'(k), 32'd19);
        check("t2_simul_valid", 32'(job_valid), 32'd0);

        // Test 6: asynchronous reset mid-frame
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_x", 32'(job_x), 32'd19);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_valid", 32'(job_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(frame_done), 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_x", 32'(job_x), 32'd0);
        check("t6_y", 32'(job_y), 32'd0);
        check("t6_sof", 32'(job_sof), 32'd0);
        check("t6_eol", 32'(job_eol), 32'd0);
`ifdef CAMERA_SHADOW_EN
        check("t6_cam_zero", 32'(cam_out == '0), 32'd1);
`endif
        run_en = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Test 3: full 200x200 frame under random backpressure
        ready_mode = 2;
        res_mode   = 1;
        run_en     = 1'b1;
        wait_valid(10, "t3");
        run_en = 1'b0;
        wait_done(90000, "t3");
        check("t3_jobs", 32'(last_frame_jobs), 32'd40000);
        step();
        check("t3_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);

`ifdef CAMERA_SHADOW_EN
        // Shadowed camera holds for the frame, updates at the next load
        ready_mode = 1;
        cfg_width  = 13'd4;
        cfg_height = 13'd2;
        cfg_cam    = cam_a;
        run_en     = 1'b1;
        wait_valid(10, "sh");
        cfg_cam = cam_b;
        repeat (3) begin
            step();
            check("sh_cam_hold", 32'(cam_out == cam_a), 32'd1);
        end
        wait_done(100, "sh");
        repeat (2) step();
        check("sh_cam_new", 32'(cam_out == cam_b), 32'd1);
        run_en = 1'b0;
        wait_done(100, "sh2");
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
